// File: rtl/vdu_pkg.sv
// -----------------------------------------------------------------------------
// vdu_pkg
// Types and constants shared by the text VDU, its console front end and the
// CPU-side blocks that feed it.
//   console_state_t : console FSM states
//   CH_*            : control character codes the console decodes
// -----------------------------------------------------------------------------
package vdu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_SCROLL_RD = 3'd2,
    ST_SCROLL_WR = 3'd3,
    ST_FILL_LAST = 3'd4,
    ST_CLEAR_ALL = 3'd5
  } console_state_t;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

endpackage

// File: rtl/vdu_mem_arb.sv
// -----------------------------------------------------------------------------
// vdu_mem_arb
// Fixed-priority mux for the single text RAM port. A VDU display read always
// wins; the console write side is masked and told to stall for that cycle.
// Ports:
//   i_vdu_read_en / i_vdu_read_addr : VDU display fetch request
//   i_con_addr / i_con_we / i_con_wdata : console side request
//   o_mem_addr / o_mem_we / o_mem_wdata : to the text RAM
//   o_con_stall : console must hold its state this cycle
// -----------------------------------------------------------------------------
module vdu_mem_arb #(
  parameter int ADDR_W = 16
) (
  input  logic              i_vdu_read_en,
  input  logic [ADDR_W-1:0] i_vdu_read_addr,
  input  logic [ADDR_W-1:0] i_con_addr,
  input  logic              i_con_we,
  input  logic [7:0]        i_con_wdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata,
  output logic              o_con_stall
);

  assign o_mem_addr  = i_vdu_read_en ? i_vdu_read_addr : i_con_addr;
  assign o_mem_we    = i_con_we && !i_vdu_read_en;
  assign o_mem_wdata = i_con_wdata;
  assign o_con_stall = i_vdu_read_en;

endmodule

// File: rtl/vdu_console.sv
// -----------------------------------------------------------------------------
// vdu_console
// Character-stream front end for the text VDU. Takes one byte per valid/ready
// handshake, keeps the cursor, writes glyph codes into the shared text RAM and
// performs newline, carriage return, backspace, clear-screen and scroll-up.
// The VDU display fetch owns the RAM port whenever it asks for it.
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_char, i_char_valid         : incoming byte stream
//   o_char_ready                 : byte accepted this cycle if valid
//   o_busy                       : clearing or scrolling in progress
//   o_cur_col, o_cur_row         : cursor position
//   i_vdu_read_en/addr           : VDU display read request
//   o_vdu_data                   : RAM read data returned to the VDU
//   o_mem_addr/we/wdata          : text RAM port
//   i_mem_rdata                  : text RAM read data (1-cycle latency)
// -----------------------------------------------------------------------------
module vdu_console
  import vdu_pkg::*;
#(
  parameter int         BASE_ADDR  = 0,
  parameter int         COLS       = 60,
  parameter int         ROWS       = 34,
  parameter int         ADDR_W     = 16,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_char,
  input  logic              i_char_valid,
  output logic              o_char_ready,
  output logic              o_busy,
  output logic [7:0]        o_cur_col,
  output logic [7:0]        o_cur_row,
  input  logic              i_vdu_read_en,
  input  logic [ADDR_W-1:0] i_vdu_read_addr,
  output logic [7:0]        o_vdu_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata
);

  localparam logic [ADDR_W-1:0] BASE_A      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_ROW_A  = ADDR_W'(BASE_ADDR + (ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] SCROLL_LAST = ADDR_W'((ROWS - 1) * COLS - 1);
  localparam logic [ADDR_W-1:0] FILL_LAST   = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] CLEAR_LAST  = ADDR_W'(COLS * ROWS - 1);
  localparam logic [7:0]        COL_MAX     = 8'(COLS - 1);
  localparam logic [7:0]        ROW_MAX     = 8'(ROWS - 1);

  console_state_t    state_q, state_d;
  logic [7:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;        // cell address of the cursor
  logic [ADDR_W-1:0] cnt_q, cnt_d;          // scroll / fill / clear offset
  logic              scroll_pend_q, scroll_pend_d;
  logic              first_q, first_d;      // first cycle of SCROLL_WR
  logic [7:0]        hold_q, hold_d;        // scroll data captured from RAM
  logic [7:0]        wdata_q, wdata_d;      // pending single-cell write
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic              con_we;
  logic [ADDR_W-1:0] con_addr;
  logic [7:0]        con_wdata;
  logic              stall;
  logic              ready;

  vdu_mem_arb #(.ADDR_W(ADDR_W)) u_arb (
    .i_vdu_read_en   (i_vdu_read_en),
    .i_vdu_read_addr (i_vdu_read_addr),
    .i_con_addr      (con_addr),
    .i_con_we        (con_we && !i_rst),
    .i_con_wdata     (con_wdata),
    .o_mem_addr      (o_mem_addr),
    .o_mem_we        (o_mem_we),
    .o_mem_wdata     (o_mem_wdata),
    .o_con_stall     (stall)
  );

  assign ready        = (state_q == ST_IDLE) && !i_rst;
  assign o_char_ready = ready;
  assign o_cur_col    = col_q;
  assign o_cur_row    = row_q;
  assign o_vdu_data   = i_mem_rdata;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    scroll_pend_d = scroll_pend_q;
    first_d       = first_q;
    hold_d        = hold_q;
    wdata_d       = wdata_q;
    wr_addr_d     = wr_addr_q;
    con_we        = 1'b0;
    con_addr      = wr_addr_q;
    con_wdata     = wdata_q;
    o_busy        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Idle never touches the RAM port, so it decodes even while the VDU reads.
        if (i_char_valid && ready) begin
          case (i_char)
            CH_CR: begin
              col_d  = '0;
              addr_d = addr_q - ADDR_W'(col_q);
            end
            CH_LF: begin
              col_d = '0;
              if (row_q == ROW_MAX) begin
                addr_d  = LAST_ROW_A;
                cnt_d   = '0;
                state_d = ST_SCROLL_RD;
              end else begin
                row_d  = row_q + 8'd1;
                addr_d = addr_q - ADDR_W'(col_q) + COLS_A;
              end
            end
            CH_BS: begin
              if (col_q != 8'd0 || row_q != 8'd0) begin
                if (col_q == 8'd0) begin
                  col_d = COL_MAX;
                  row_d = row_q - 8'd1;
                end else begin
                  col_d = col_q - 8'd1;
                end
                addr_d    = addr_q - ADDR_W'(1);
                wr_addr_d = addr_q - ADDR_W'(1);
                wdata_d   = BLANK_CHAR;
                state_d   = ST_WRITE;
              end
            end
            CH_FF: begin
              col_d   = '0;
              row_d   = '0;
              addr_d  = BASE_A;
              cnt_d   = '0;
              state_d = ST_CLEAR_ALL;
            end
            default: begin
              wr_addr_d = addr_q;
              wdata_d   = i_char;
              state_d   = ST_WRITE;
              if (col_q == COL_MAX) begin
                col_d = '0;
                if (row_q == ROW_MAX) begin
                  // Cursor lands at the start of the last row; the scroll
                  // runs once the glyph itself has been written.
                  addr_d        = LAST_ROW_A;
                  scroll_pend_d = 1'b1;
                end else begin
                  row_d  = row_q + 8'd1;
                  addr_d = addr_q + ADDR_W'(1);
                end
              end else begin
                col_d  = col_q + 8'd1;
                addr_d = addr_q + ADDR_W'(1);
              end
            end
          endcase
        end
      end

      ST_WRITE: begin
        con_we = 1'b1;
        if (!stall) begin
          scroll_pend_d = 1'b0;
          cnt_d         = '0;
          state_d       = scroll_pend_q ? ST_SCROLL_RD : ST_IDLE;
        end
      end

      ST_SCROLL_RD: begin
        o_busy   = 1'b1;
        con_addr = BASE_A + cnt_q + COLS_A;
        if (!stall) begin
          first_d = 1'b1;
          state_d = ST_SCROLL_WR;
        end
      end

      ST_SCROLL_WR: begin
        o_busy   = 1'b1;
        con_we   = 1'b1;
        con_addr = BASE_A + cnt_q;
        // Read data is only valid in the first cycle; later retries use the hold copy.
        con_wdata = first_q ? i_mem_rdata : hold_q;
        if (first_q) begin
          hold_d  = i_mem_rdata;
          first_d = 1'b0;
        end
        if (!stall) begin
          if (cnt_q == SCROLL_LAST) begin
            cnt_d   = '0;
            state_d = ST_FILL_LAST;
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = ST_SCROLL_RD;
          end
        end
      end

      ST_FILL_LAST: begin
        o_busy    = 1'b1;
        con_we    = 1'b1;
        con_addr  = LAST_ROW_A + cnt_q;
        con_wdata = BLANK_CHAR;
        if (!stall) begin
          if (cnt_q == FILL_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end

      ST_CLEAR_ALL: begin
        o_busy    = 1'b1;
        con_we    = 1'b1;
        con_addr  = BASE_A + cnt_q;
        con_wdata = BLANK_CHAR;
        if (!stall) begin
          if (cnt_q == CLEAR_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_CLEAR_ALL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_CLEAR_ALL;
      col_q         <= '0;
      row_q         <= '0;
      addr_q        <= BASE_A;
      cnt_q         <= '0;
      scroll_pend_q <= 1'b0;
      first_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      scroll_pend_q <= scroll_pend_d;
      first_q       <= first_d;
    end
  end

  always_ff @(posedge i_clk) begin
    hold_q    <= hold_d;
    wdata_q   <= wdata_d;
    wr_addr_q <= wr_addr_d;
  end

endmodule

// File: tb/tb_vdu_console.sv
module tb_vdu_console;

  localparam int NCELL = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ch;
  logic        ch_valid;
  logic        ready;
  logic        busy;
  logic [7:0]  cur_col;
  logic [7:0]  cur_row;
  logic        vdu_en;
  logic [15:0] vdu_addr;
  logic [7:0]  vdu_data;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int bad_addr = 0;
  bit rand_vdu = 0;

  logic [7:0] ram [0:63];
  logic [7:0] exp_ram [0:NCELL-1];
  int mcol, mrow;

  always #5 clk = ~clk;

  vdu_console #(
    .BASE_ADDR(0), .COLS(8), .ROWS(4), .ADDR_W(16), .BLANK_CHAR(8'h20)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_char(ch), .i_char_valid(ch_valid),
    .o_char_ready(ready), .o_busy(busy), .o_cur_col(cur_col), .o_cur_row(cur_row),
    .i_vdu_read_en(vdu_en), .i_vdu_read_addr(vdu_addr), .o_vdu_data(vdu_data),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // Single-port RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      ram[mem_addr[5:0]] <= mem_wdata;
      wr_cnt = wr_cnt + 1;
      if (mem_addr >= 16'(NCELL)) bad_addr = bad_addr + 1;
    end
    mem_rdata <= ram[mem_addr[5:0]];
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < NCELL; i++) exp_ram[i] = 8'h20;
    mcol = 0;
    mrow = 0;
  endtask

  task automatic model_scroll();
    for (int i = 0; i < 24; i++) exp_ram[i] = exp_ram[i + 8];
    for (int i = 24; i < 32; i++) exp_ram[i] = 8'h20;
  endtask

  task automatic model_apply(input logic [7:0] c);
    case (c)
      8'h0D: mcol = 0;
      8'h0A: begin
        mcol = 0;
        if (mrow < 3) mrow++; else model_scroll();
      end
      8'h08: begin
        if (!(mcol == 0 && mrow == 0)) begin
          if (mcol == 0) begin mcol = 7; mrow--; end
          else mcol--;
          exp_ram[mrow * 8 + mcol] = 8'h20;
        end
      end
      8'h0C: model_reset();
      default: begin
        exp_ram[mrow * 8 + mcol] = c;
        if (mcol < 7) mcol++;
        else begin
          mcol = 0;
          if (mrow < 3) mrow++; else model_scroll();
        end
      end
    endcase
  endtask

  // ---------------- drive helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (rand_vdu) begin
      vdu_en   = ($urandom_range(0, 2) == 0);
      vdu_addr = 16'($urandom_range(0, NCELL - 1));
    end
  endtask

  task automatic send(input logic [7:0] c);
    bit acc = 0;
    ch = c;
    ch_valid = 1'b1;
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge clk);
      acc = (ready === 1'b1);
      next_cycle();
    end
    ch_valid = 1'b0;
    if (acc) model_apply(c);
    else check_val("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      done = (ready === 1'b1) && (busy === 1'b0);
      next_cycle();
    end
    if (!done) check_val("idle_timeout", 0, 1);
  endtask

  task automatic check_cursor(input string tag);
    check_val({tag, "_col"}, 32'(cur_col), 32'(mcol));
    check_val({tag, "_row"}, 32'(cur_row), 32'(mrow));
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < NCELL; i++)
      check_val($sformatf("%s_ram%0d", tag, i), 32'(ram[i]), 32'(exp_ram[i]));
  endtask

  // Reset for one cycle, then expect the full clear sweep.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_we", 32'(mem_we), 0);
    check_val("rst_ready", 32'(ready), 0);
    next_cycle();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < NCELL; i++) begin
      @(negedge clk);
      check_val($sformatf("clr_we%0d", i), 32'(mem_we), 1);
      check_val($sformatf("clr_addr%0d", i), 32'(mem_addr), 32'(i));
      check_val($sformatf("clr_data%0d", i), 32'(mem_wdata), 32'h20);
      next_cycle();
    end
    @(negedge clk);
    check_val("post_clr_ready", 32'(ready), 1);
    check_cursor("post_clr");
    next_cycle();
  endtask

  initial begin
    int n;
    int snap;
    logic [7:0] c;
    rst = 1'b1;
    ch = 8'h00;
    ch_valid = 1'b0;
    vdu_en = 1'b0;
    vdu_addr = '0;
    for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    model_reset();

    do_reset();

    // 'A' on an idle port: write lands the cycle after acceptance
    send(8'h41);
    @(negedge clk);
    check_val("a_we", 32'(mem_we), 1);
    check_val("a_addr", 32'(mem_addr), 0);
    check_val("a_data", 32'(mem_wdata), 32'h41);
    check_cursor("a");
    next_cycle();

    // 'B' with the VDU holding the port for 5 cycles
    send(8'h42);
    vdu_en = 1'b1;
    vdu_addr = 16'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_we", 32'(mem_we), 0);
      check_val("stall_addr", 32'(mem_addr), 5);
      check_val("stall_vdu_data", 32'(vdu_data), 32'(mem_rdata));
      if (i > 0) check_val("stall_rdata", 32'(vdu_data), 32'(exp_ram[5]));
      next_cycle();
    end
    vdu_en = 1'b0;
    @(negedge clk);
    check_val("b_we", 32'(mem_we), 1);
    check_val("b_addr", 32'(mem_addr), 1);
    check_val("b_data", 32'(mem_wdata), 32'h42);
    next_cycle();
    wait_idle();
    check_ram("ab");

    // Fill to (7,3) then 'Z' forces a scroll
    send(8'h0C);
    wait_idle();
    for (int i = 0; i < 31; i++) send(8'(8'h30 + i));
    wait_idle();
    check_cursor("pre_scroll");
    send(8'h5A);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      if (busy === 1'b1) n++;
      next_cycle();
    end
    check_val("scroll_cycles", 32'(n), 56);
    next_cycle();
    check_cursor("scroll");
    check_ram("scroll");

    // Backspace across a row boundary
    send(8'h0C);
    wait_idle();
    for (int i = 0; i < 8; i++) send(8'h61);
    send(8'h08);
    @(negedge clk);
    check_val("bs_we", 32'(mem_we), 1);
    check_val("bs_addr", 32'(mem_addr), 7);
    check_val("bs_data", 32'(mem_wdata), 32'h20);
    check_cursor("bs");
    next_cycle();
    wait_idle();
    check_ram("bs");

    // Backspace at home: nothing happens
    send(8'h0C);
    wait_idle();
    snap = wr_cnt;
    send(8'h08);
    for (int i = 0; i < 3; i++) next_cycle();
    check_val("bs00_writes", 32'(wr_cnt), 32'(snap));
    check_cursor("bs00");

    // CR at (5,2): cursor only
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h62);
    wait_idle();
    check_cursor("pre_cr");
    snap = wr_cnt;
    send(8'h0D);
    for (int i = 0; i < 3; i++) next_cycle();
    check_val("cr_writes", 32'(wr_cnt), 32'(snap));
    check_cursor("cr");
    check_ram("cr");

    // Random stream with random VDU contention
    rand_vdu = 1;
    for (int i = 0; i < 250; i++) begin
      n = $urandom_range(0, 15);
      if (n == 0) c = 8'h0D;
      else if (n == 1) c = 8'h0A;
      else if (n == 2) c = 8'h08;
      else if (n == 3 && $urandom_range(0, 3) == 0) c = 8'h0C;
      else c = 8'(8'h41 + $urandom_range(0, 25));
      send(c);
      @(negedge clk);
      check_cursor("rnd");
      check_val("rnd_vdu_data", 32'(vdu_data), 32'(mem_rdata));
      next_cycle();
    end
    rand_vdu = 0;
    vdu_en = 1'b0;
    wait_idle();
    check_ram("rnd");

    // Reset in the middle of a scroll
    send(8'h0C);
    wait_idle();
    for (int i = 0; i < 32; i++) send(8'(8'h30 + i));
    for (int i = 0; i < 20; i++) next_cycle();
    do_reset();
    wait_idle();
    check_ram("rst_mid");
    check_cursor("rst_mid");

    check_val("addr_range", 32'(bad_addr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
